// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Define SD_INIT_CRC7_EN to compute sd_crc serially (40-cycle issue) instead of the constant table.
module sd_init_sequencer #(
  parameter int CMD0_RETRIES   = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  output logic [5:0]  sd_cmd,
  output logic [31:0] sd_arg,
  output logic [6:0]  sd_crc,
  output logic [2:0]  sd_nresponse,
  output logic        sd_start,
  input  logic        sd_done,
  input  logic [7:0]  sd_resp,
  input  logic [31:0] sd_resp_ext,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  err_code,
  output logic        card_hc
);

  localparam int C0W  = $clog2(CMD0_RETRIES + 1);
  localparam int A41W = $clog2(ACMD41_RETRIES + 1);
  localparam logic [C0W-1:0]  C0_MAX  = C0W'(CMD0_RETRIES);
  localparam logic [A41W-1:0] A41_MAX = A41W'(ACMD41_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_DONE, S_ERROR
  } state_e;

  // REL waits for sd_done low before anything new is loaded onto the bus.
  typedef enum logic [1:0] {PH_REL, PH_ISSUE, PH_WAIT} phase_e;

  state_e          st_q, st_d;
  phase_e          ph_q, ph_d;
  logic [5:0]      cmd_q, cmd_d;
  logic [31:0]     arg_q, arg_d;
  logic [6:0]      crc_q, crc_d;
  logic [2:0]      nresp_q, nresp_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [2:0]      err_q, err_d;
  logic            hc_q, hc_d;
  logic            hcs_q, hcs_d;
  logic [C0W-1:0]  c0_q, c0_d, c0_inc;
  logic [A41W-1:0] a41_q, a41_d, a41_inc;

  logic [5:0]      ld_cmd;
  logic [31:0]     ld_arg;
  logic [2:0]      ld_nresp;

  logic            unused_ext;
  assign unused_ext = ^{sd_resp_ext[31], sd_resp_ext[29:12]};

  // Saturating increments: counters never wrap past their limit.
  assign c0_inc  = (c0_q  == C0_MAX)  ? c0_q  : c0_q  + 1'b1;
  assign a41_inc = (a41_q == A41_MAX) ? a41_q : a41_q + 1'b1;

  always_comb begin
    ld_cmd   = 6'd0;
    ld_arg   = 32'h0;
    ld_nresp = 3'd0;
    case (st_q)
      S_CMD8: begin
        ld_cmd   = 6'd8;
        ld_arg   = 32'h0000_01AA;
        ld_nresp = 3'd4;
      end
      S_CMD55:  ld_cmd = 6'd55;
      S_ACMD41: begin
        ld_cmd = 6'd41;
        ld_arg = hcs_q ? 32'h4000_0000 : 32'h0;
      end
      S_CMD58: begin
        ld_cmd   = 6'd58;
        ld_nresp = 3'd4;
      end
      default: ;
    endcase
  end

`ifdef SD_INIT_CRC7_EN
  logic [5:0]  bit_q, bit_d;
  logic [39:0] frame;
  assign frame = {2'b01, cmd_q, arg_q};

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_q <= '0;
    else        bit_q <= bit_d;
  end
`else
  logic [6:0] ld_crc;

  always_comb begin
    ld_crc = 7'h4A;
    case (st_q)
      S_CMD8:   ld_crc = 7'h43;
      S_CMD55:  ld_crc = 7'h32;
      S_ACMD41: ld_crc = hcs_q ? 7'h3B : 7'h72;
      S_CMD58:  ld_crc = 7'h7E;
      default:  ;
    endcase
  end
`endif

  always_comb begin
    st_d    = st_q;
    ph_d    = ph_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    crc_d   = crc_q;
    nresp_d = nresp_q;
    start_d = start_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;
    hc_d    = hc_q;
    hcs_d   = hcs_q;
    c0_d    = c0_q;
    a41_d   = a41_q;
`ifdef SD_INIT_CRC7_EN
    bit_d   = bit_q;
`endif

    if (st_q == S_IDLE || st_q == S_DONE || st_q == S_ERROR) begin
      if (init_start) begin
        st_d    = S_CMD0;
        ph_d    = PH_REL;
        done_d  = 1'b0;
        error_d = 1'b0;
        err_d   = 3'd0;
        hc_d    = 1'b0;
        hcs_d   = 1'b0;
        c0_d    = '0;
        a41_d   = '0;
      end
    end else begin
      case (ph_q)
        PH_REL: begin
          if (!sd_done) begin
            ph_d    = PH_ISSUE;
            cmd_d   = ld_cmd;
            arg_d   = ld_arg;
            nresp_d = ld_nresp;
`ifdef SD_INIT_CRC7_EN
            crc_d   = 7'h00;
            bit_d   = 6'd0;
`else
            crc_d   = ld_crc;
`endif
          end
        end
        PH_ISSUE: begin
`ifdef SD_INIT_CRC7_EN
          crc_d = crc7_step(crc_q, frame[6'd39 - bit_q]);
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'd39) begin
            ph_d    = PH_WAIT;
            start_d = 1'b1;
          end
`else
          ph_d    = PH_WAIT;
          start_d = 1'b1;
`endif
        end
        PH_WAIT: begin
          if (sd_done) begin
            start_d = 1'b0;
            ph_d    = PH_REL;
            case (st_q)
              S_CMD0: begin
                if (sd_resp == 8'h01) st_d = S_CMD8;
                else begin
                  c0_d = c0_inc;
                  if (c0_inc == C0_MAX) begin
                    st_d = S_ERROR; error_d = 1'b1; err_d = 3'd1;
                  end
                end
              end
              S_CMD8: begin
                if (sd_resp == 8'h01 && sd_resp_ext[11:0] == 12'h1AA) begin
                  hcs_d = 1'b1; st_d = S_CMD55;
                end else if (sd_resp == 8'h05) begin
                  hcs_d = 1'b0; st_d = S_CMD55;
                end else begin
                  st_d = S_ERROR; error_d = 1'b1; err_d = 3'd2;
                end
              end
              S_CMD55: begin
                if (sd_resp == 8'h00 || sd_resp == 8'h01) st_d = S_ACMD41;
                else begin
                  st_d = S_ERROR; error_d = 1'b1; err_d = 3'd3;
                end
              end
              S_ACMD41: begin
                if (sd_resp == 8'h00) begin
                  if (hcs_q) st_d = S_CMD58;
                  else begin
                    st_d = S_DONE; done_d = 1'b1; hc_d = 1'b0;
                  end
                end else if (sd_resp == 8'h01) begin
                  a41_d = a41_inc;
                  if (a41_inc == A41_MAX) begin
                    st_d = S_ERROR; error_d = 1'b1; err_d = 3'd4;
                  end else st_d = S_CMD55;
                end else begin
                  st_d = S_ERROR; error_d = 1'b1; err_d = 3'd3;
                end
              end
              S_CMD58: begin
                if (sd_resp == 8'h00) begin
                  st_d = S_DONE; done_d = 1'b1; hc_d = sd_resp_ext[30];
                end else begin
                  st_d = S_ERROR; error_d = 1'b1; err_d = 3'd5;
                end
              end
              default: ;
            endcase
          end
        end
        default: ph_d = PH_REL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      ph_q    <= PH_REL;
      cmd_q   <= '0;
      arg_q   <= '0;
      crc_q   <= '0;
      nresp_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= '0;
      hc_q    <= 1'b0;
      hcs_q   <= 1'b0;
      c0_q    <= '0;
      a41_q   <= '0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      crc_q   <= crc_d;
      nresp_q <= nresp_d;
      start_q <= start_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
      hc_q    <= hc_d;
      hcs_q   <= hcs_d;
      c0_q    <= c0_d;
      a41_q   <= a41_d;
    end
  end

  assign sd_cmd       = cmd_q;
  assign sd_arg       = arg_q;
  assign sd_crc       = crc_q;
  assign sd_nresponse = nresp_q;
  assign sd_start     = start_q;
  assign busy         = !(st_q == S_IDLE || st_q == S_DONE || st_q == S_ERROR);
  assign init_done    = done_q;
  assign init_error   = error_q;
  assign err_code     = err_q;
  assign card_hc      = hc_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: scenario table feeds an expected-command queue that a
// responsive sd_controller model pops and checks; a few hand sequences cover reset/busy corners.
module tb_sd_init_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic [5:0]  sd_cmd;
  logic [31:0] sd_arg;
  logic [6:0]  sd_crc;
  logic [2:0]  sd_nresponse;
  logic        sd_start;
  logic        sd_done;
  logic [7:0]  sd_resp;
  logic [31:0] sd_resp_ext;
  logic        busy, init_done, init_error, card_hc;
  logic [2:0]  err_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sd_init_sequencer #(.CMD0_RETRIES(8), .ACMD41_RETRIES(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .sd_cmd(sd_cmd), .sd_arg(sd_arg), .sd_crc(sd_crc), .sd_nresponse(sd_nresponse),
    .sd_start(sd_start), .sd_done(sd_done), .sd_resp(sd_resp), .sd_resp_ext(sd_resp_ext),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .err_code(err_code), .card_hc(card_hc)
  );

  typedef struct {
    int          scn;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [2:0]  nresp;
    logic [7:0]  r1;
    logic [31:0] ext;
    bit          poke;   // pulse init_start together with sd_done
    int          hold;   // extra cycles sd_done stays high
  } step_t;

  typedef struct {
    logic       done;
    logic       error;
    logic [2:0] code;
    logic       hc;
  } fin_t;

  localparam int NS = 7;
  step_t tbl[$];
  step_t exp_q[$];
  fin_t  fin[NS];

  function automatic step_t mk(int s, logic [5:0] c, logic [31:0] a, logic [6:0] k,
                               logic [2:0] n, logic [7:0] r, logic [31:0] e, bit p, int h);
    step_t t;
    t.scn = s; t.cmd = c; t.arg = a; t.crc = k; t.nresp = n;
    t.r1 = r; t.ext = e; t.poke = p; t.hold = h;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic serve();
    step_t s;
    int n;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      n = 0;
      while (sd_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      if (sd_start !== 1'b1) begin
        chk("start_timeout", {31'd0, sd_start}, 32'd1);
        exp_q.delete();
        return;
      end
      chk("cmd", {26'd0, sd_cmd}, {26'd0, s.cmd});
      chk("arg", sd_arg, s.arg);
      chk("crc", {25'd0, sd_crc}, {25'd0, s.crc});
      chk("nresp", {29'd0, sd_nresponse}, {29'd0, s.nresp});
      @(negedge clk);
      chk("start_held", {31'd0, sd_start}, 32'd1);
      if (s.poke) init_start = 1'b1;
      sd_done = 1'b1; sd_resp = s.r1; sd_resp_ext = s.ext;
      @(negedge clk);
      init_start = 1'b0;
      chk("start_drop", {31'd0, sd_start}, 32'd0);
      for (int h = 0; h < s.hold; h++) begin
        chk("cmd_stable", {26'd0, sd_cmd}, {26'd0, s.cmd});
        chk("no_start_done_hi", {31'd0, sd_start}, 32'd0);
        @(negedge clk);
      end
      sd_done = 1'b0; sd_resp = 8'h00; sd_resp_ext = 32'h0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  quiet;
    // Scenario 0: v2 card with a busy-time init_start and one on the final sd_done.
    tbl.push_back(mk(0, 6'd0,  32'h0,          7'h4A, 3'd0, 8'h01, 32'h0,          0, 0));
    tbl.push_back(mk(0, 6'd8,  32'h0000_01AA,  7'h43, 3'd4, 8'h01, 32'h0000_01AA,  0, 2));
    tbl.push_back(mk(0, 6'd55, 32'h0,          7'h32, 3'd0, 8'h01, 32'h0,          1, 0));
    tbl.push_back(mk(0, 6'd41, 32'h4000_0000,  7'h3B, 3'd0, 8'h01, 32'h0,          0, 0));
    tbl.push_back(mk(0, 6'd55, 32'h0,          7'h32, 3'd0, 8'h01, 32'h0,          0, 0));
    tbl.push_back(mk(0, 6'd41, 32'h4000_0000,  7'h3B, 3'd0, 8'h00, 32'h0,          0, 0));
    tbl.push_back(mk(0, 6'd58, 32'h0,          7'h7E, 3'd4, 8'h00, 32'hC0FF_8000,  1, 0));
    fin[0] = '{1'b1, 1'b0, 3'd0, 1'b1};
    // Scenario 1: v1 card.
    tbl.push_back(mk(1, 6'd0,  32'h0,          7'h4A, 3'd0, 8'h01, 32'h0, 0, 0));
    tbl.push_back(mk(1, 6'd8,  32'h0000_01AA,  7'h43, 3'd4, 8'h05, 32'h0, 0, 0));
    tbl.push_back(mk(1, 6'd55, 32'h0,          7'h32, 3'd0, 8'h01, 32'h0, 0, 0));
    tbl.push_back(mk(1, 6'd41, 32'h0,          7'h72, 3'd0, 8'h00, 32'h0, 0, 1));
    fin[1] = '{1'b1, 1'b0, 3'd0, 1'b0};
    // Scenario 2: CMD0 never answers idle.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(2, 6'd0, 32'h0, 7'h4A, 3'd0, 8'hFF, 32'h0, 0, 0));
    fin[2] = '{1'b0, 1'b1, 3'd1, 1'b0};
    // Scenario 3: ACMD41 stays busy for the whole retry budget.
    tbl.push_back(mk(3, 6'd0, 32'h0,         7'h4A, 3'd0, 8'h01, 32'h0,         0, 0));
    tbl.push_back(mk(3, 6'd8, 32'h0000_01AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(3, 6'd55, 32'h0,         7'h32, 3'd0, 8'h01, 32'h0, 0, 0));
      tbl.push_back(mk(3, 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h01, 32'h0, 0, 0));
    end
    fin[3] = '{1'b0, 1'b1, 3'd4, 1'b0};
    // Scenario 4: bad CMD8 echo.
    tbl.push_back(mk(4, 6'd0, 32'h0,         7'h4A, 3'd0, 8'h01, 32'h0,         0, 0));
    tbl.push_back(mk(4, 6'd8, 32'h0000_01AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AB, 0, 0));
    fin[4] = '{1'b0, 1'b1, 3'd2, 1'b0};
    // Scenario 5: CMD58 rejected.
    tbl.push_back(mk(5, 6'd0,  32'h0,         7'h4A, 3'd0, 8'h01, 32'h0,         0, 0));
    tbl.push_back(mk(5, 6'd8,  32'h0000_01AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA, 0, 0));
    tbl.push_back(mk(5, 6'd55, 32'h0,         7'h32, 3'd0, 8'h00, 32'h0,         0, 0));
    tbl.push_back(mk(5, 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h00, 32'h0,         0, 0));
    tbl.push_back(mk(5, 6'd58, 32'h0,         7'h7E, 3'd4, 8'h04, 32'h0,         0, 0));
    fin[5] = '{1'b0, 1'b1, 3'd5, 1'b0};
    // Scenario 6: re-init after ERROR completes as a v1 card.
    tbl.push_back(mk(6, 6'd0,  32'h0,         7'h4A, 3'd0, 8'h01, 32'h0, 0, 0));
    tbl.push_back(mk(6, 6'd8,  32'h0000_01AA, 7'h43, 3'd4, 8'h05, 32'h0, 0, 0));
    tbl.push_back(mk(6, 6'd55, 32'h0,         7'h32, 3'd0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(mk(6, 6'd41, 32'h0,         7'h72, 3'd0, 8'h00, 32'h0, 0, 0));
    fin[6] = '{1'b1, 1'b0, 3'd0, 1'b0};

    rst_n = 1'b0; init_start = 1'b0; sd_done = 1'b0; sd_resp = 8'h00; sd_resp_ext = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_start", {31'd0, sd_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_error", {31'd0, init_error}, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    chk("rst_hc", {31'd0, card_hc}, 32'd0);
    chk("rst_cmd", {26'd0, sd_cmd}, 32'd0);
    chk("rst_crc", {25'd0, sd_crc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NS; i++) begin
      foreach (tbl[j]) if (tbl[j].scn == i) exp_q.push_back(tbl[j]);
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      chk("busy_set", {31'd0, busy}, 32'd1);
      chk("err_clr", {29'd0, err_code}, 32'd0);
      chk("done_clr", {31'd0, init_done}, 32'd0);
      chk("error_clr", {31'd0, init_error}, 32'd0);
      serve();
      n = 0;
      while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("fin_busy", {31'd0, busy}, 32'd0);
      chk("fin_done", {31'd0, init_done}, {31'd0, fin[i].done});
      chk("fin_error", {31'd0, init_error}, {31'd0, fin[i].error});
      chk("fin_err_code", {29'd0, err_code}, {29'd0, fin[i].code});
      chk("fin_hc", {31'd0, card_hc}, {31'd0, fin[i].hc});
      quiet = 1'b1;
      repeat (6) begin @(negedge clk); if (sd_start !== 1'b0) quiet = 1'b0; end
      chk("quiet_after", {31'd0, quiet}, 32'd1);
    end

    // Reset while sd_start is high must drop it without a clock edge.
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    n = 0;
    while (sd_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("pre_rst_start", {31'd0, sd_start}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_start", {31'd0, sd_start}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (5) begin @(negedge clk); if (sd_start !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    chk("idle_after_rst", {31'd0, quiet}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Drives the SD card SPI-mode power-up sequence: CMD0, CMD8, then a CMD55/ACMD41 loop, then CMD58.
- Sits directly upstream of sd_controller. Supplies its cmd/arg/crc/nresponse/start inputs and consumes its done and response outputs.
- Reports init completion, error code and card capacity class to the system.

Parameters:
- CMD0_RETRIES, 8: CMD0 attempts before error.
- ACMD41_RETRIES, 1000: CMD55/ACMD41 pairs before timeout error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- init_start  in  1  pulse; begin sequence (ignored while busy)
- sd_cmd  out  6  command index to sd_controller
- sd_arg  out  32  command argument
- sd_crc  out  7  CRC7 of the command frame
- sd_nresponse  out  3  extra response bytes after R1 (0 = R1, 4 = R3/R7)
- sd_start  out  1  command request
- sd_done  in  1  sd_controller command complete (level)
- sd_resp  in  8  R1 byte, valid while sd_done=1
- sd_resp_ext  in  32  trailing 4 response bytes, MSB first, valid while sd_done=1
- busy  out  1  sequence in progress
- init_done  out  1  sequence succeeded (sticky)
- init_error  out  1  sequence failed (sticky)
- err_code  out  3  failure cause
- card_hc  out  1  card is SDHC/SDXC (CCS bit)

Behaviour:
- Reset (asynchronous):
  - State IDLE; counters 0.
  - All outputs 0, except sd_crc=0 and err_code=0.
- Command handshake:
  - Sequencer loads sd_cmd/sd_arg/sd_crc/sd_nresponse, then raises sd_start the next cycle.
  - sd_start is held high until sd_done is sampled 1.
  - On that cycle, sd_resp and sd_resp_ext are captured and sd_start drops.
  - The sequencer waits for sd_done=0 before loading the next command.
  - cmd/arg/crc stay stable from sd_start rise until sd_done is seen low.
- States: IDLE, CMD0, CMD8, CMD55, ACMD41, CMD58, DONE, ERROR. Each command state contains ISSUE, WAIT_DONE and WAIT_RELEASE sub-phases.
- IDLE/DONE/ERROR:
  - init_start=1 goes to CMD0.
  - Clears init_done, init_error, err_code, card_hc and both retry counters.
  - Sets busy=1.
- CMD0 (arg 0, nresp 0):
  - R1==0x01 goes to CMD8.
  - Otherwise the CMD0 counter increments. When the counter reaches CMD0_RETRIES, go to ERROR with err_code=1; else reissue CMD0.
- CMD8 (arg 0x000001AA, nresp 4):
  - R1==0x01 and ext[11:0]==0x1AA: set v2 and hcs=1, go to CMD55.
  - R1==0x05 (illegal command): set v1 and hcs=0, go to CMD55.
  - Otherwise ERROR with err_code=2.
- CMD55 (arg 0, nresp 0):
  - R1 of 0x00 or 0x01 goes to ACMD41.
  - Otherwise ERROR with err_code=3.
- ACMD41 (cmd 41, arg 0x40000000 if hcs else 0, nresp 0):
  - R1==0x00: v2 goes to CMD58; v1 goes to DONE with card_hc=0.
  - R1==0x01: the ACMD41 counter increments. When it reaches ACMD41_RETRIES, go to ERROR with err_code=4; else go to CMD55.
  - Other R1 values: ERROR with err_code=3.
- CMD58 (arg 0, nresp 4):
  - R1==0x00: card_hc=ext[30], go to DONE.
  - Otherwise ERROR with err_code=5.
- DONE sets init_done=1 and busy=0. ERROR sets init_error=1 and busy=0. init_done and init_error are never both 1.
- Counter widths:
  - CMD0 counter: $clog2(CMD0_RETRIES+1).
  - ACMD41 counter: $clog2(ACMD41_RETRIES+1).
  - Counters saturate; they never wrap.
- Boundary conditions:
  - init_start asserted together with the final sd_done: ignored.
  - sd_done already high when entering ISSUE: sequencer still waits in WAIT_RELEASE for low first.
  - Reset mid-command: sd_start drops to 0 asynchronously.

Optional Feature:
- Macro SD_INIT_CRC7_EN.
- Defined:
  - sd_crc is computed by a serial CRC7 over the 40-bit frame {2'b01, cmd, arg}, polynomial x^7+x^3+1, initial value 0, one bit per clk.
  - ISSUE lasts 40 cycles before sd_start rises.
- Undefined:
  - sd_crc comes from a constant table: CMD0 0x4A, CMD8 0x43, CMD55 0x32, ACMD41(hcs) 0x3B, ACMD41(arg 0) 0x72, CMD58 0x7E.
  - ISSUE lasts 1 cycle.
- Both builds produce identical sd_crc values.

Test Plan:
- v2 card: responses 0x01 / 0x01+0x000001AA / 0x01 / 0x01 / 0x01 / 0x00 / 0x00+0xC0FF8000 -> cmds 0,8,55,41,55,41,58; init_done=1, card_hc=1, busy=0.
- v1 card: CMD8 R1=0x05, ACMD41 R1=0x00 first try -> ACMD41 arg 0, crc 0x72; no CMD58; init_done=1, card_hc=0.
- CMD0 always 0xFF -> exactly 8 CMD0 issues; init_error=1, err_code=1.
- ACMD41 always 0x01 with ACMD41_RETRIES=4 -> 4 CMD55/ACMD41 pairs; init_error=1, err_code=4.
- CMD8 echo 0x1AB -> err_code=2. CMD58 R1=0x04 -> err_code=5.
- rst_n low while sd_start=1 -> sd_start=0 with no clock edge. init_start during busy -> no effect. Re-init after ERROR clears err_code and completes.
